// File: rtl/muldiv_seq.sv
// HI/LO multiply-divide unit: 1-cycle MULT/MULTU, 32-cycle restoring DIV/DIVU, MTHI/MTLO writes.
// Latency: MUL done 2 cycles after issue, DIV 33, divide-by-zero 1; stall holds EX until DONE.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic        r_signed;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_go;
  logic        w_issue_mul;
  logic        w_issue_div;
  logic        w_is_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  assign w_go        = op_valid & ~flush;
  assign w_issue_mul = w_go & (op_code == 3'd0 || op_code == 3'd1);
  assign w_issue_div = w_go & (op_code == 3'd2 || op_code == 3'd3);
  assign w_is_signed = ~op_code[0];
  assign w_mag_a     = (w_is_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
  assign w_mag_b     = (w_is_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

  // Sign-extend for MULT, zero-extend for MULTU; the low 64 bits of the product are exact either way.
  assign w_ext_a = {{32{r_signed & r_a[31]}}, r_a};
  assign w_ext_b = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // r_a shifts dividend bits out of the top and quotient bits in at the bottom.
  assign w_shift  = {r_rem, r_a[31]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_diff[32];
  assign w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nx = {r_a[30:0], w_ge};
  assign w_q_fin  = r_neg_q ? (32'd0 - w_quo_nx) : w_quo_nx;
  assign w_r_fin  = r_neg_r ? (32'd0 - w_rem_nx) : w_rem_nx;

  assign stall = ~rst & (((r_state == S_IDLE) & (w_issue_mul | w_issue_div)) |
                         (r_state == S_MUL) | (r_state == S_DIV));
  assign done  = (r_state == S_DONE);
  assign hi    = r_hi;
  assign lo    = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_cnt    <= 5'd0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue_mul) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= w_is_signed;
            r_state  <= S_MUL;
          end else if (w_issue_div) begin
            if (src_b == 32'd0) begin
              r_state <= S_DONE;
            end else begin
              r_a      <= w_mag_a;
              r_b      <= w_mag_b;
              r_rem    <= 32'd0;
              r_cnt    <= 5'd0;
              r_signed <= w_is_signed;
              r_neg_q  <= w_is_signed & (src_a[31] ^ src_b[31]);
              r_neg_r  <= w_is_signed & src_a[31];
              r_state  <= S_DIV;
            end
          end else if (w_go && op_code == 3'd4) begin
            r_hi <= src_a;
          end else if (w_go && op_code == 3'd5) begin
            r_lo <= src_a;
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_a   <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_lo    <= w_q_fin;
              r_hi    <= w_r_fin;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed HI/LO results, stall lengths, flush and reset behaviour.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
  endtask

  // Counts stalled cycles from the issue cycle; returns with the bench sitting in the first unstalled cycle.
  task automatic run_stall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  int ns;
  int nd;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    issue(3'd0, 32'h1, 32'h1);
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_hi",    hi, 32'd0);
    chk("rst_lo",    lo, 32'd0);
    idle_in();
    tick();
    rst = 1'b0;
    tick();

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_stall_c0", 32'(stall), 32'd1);
    tick();
    chk("mult_stall_c1", 32'(stall), 32'd1);
    chk("mult_done_c1",  32'(done),  32'd0);
    tick();
    chk("mult_done_c2",  32'(done),  32'd1);
    chk("mult_stall_c2", 32'(stall), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    idle_in();
    tick();
    chk("mult_done_c3", 32'(done), 32'd0);

    // MULTU
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    run_stall(ns);
    chk("multu_stalls", ns, 32'd2);
    chk("multu_done", 32'(done), 32'd1);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    idle_in();
    tick();

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_stall(ns);
    chk("div_stalls", ns, 32'd33);
    chk("div_done", 32'(done), 32'd1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    idle_in();
    tick();

    // DIVU 100 / 7 with operands disturbed after issue
    issue(3'd3, 32'd100, 32'd7);
    tick();
    src_a = 32'hDEAD_BEEF;
    src_b = 32'd0;
    #1;
    run_stall(ns);
    chk("divu_stalls", ns, 32'd32);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    idle_in();
    tick();

    // Most-negative / -1
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_stall(ns);
    chk("ovf_stalls", ns, 32'd33);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    idle_in();
    tick();

    // MTHI / MTLO
    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi_stall", 32'(stall), 32'd0);
    tick();
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_done", 32'(done), 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    chk("mtlo_stall", 32'(stall), 32'd0);
    tick();
    chk("mtlo_lo", lo, 32'h5678);
    idle_in();

    // Divide by zero
    issue(3'd2, 32'd5, 32'd0);
    chk("dz_stall_c0", 32'(stall), 32'd1);
    tick();
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_stall_c1", 32'(stall), 32'd0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);
    idle_in();
    tick();
    chk("dz_done_off", 32'(done), 32'd0);

    // Flush in IDLE suppresses every issue
    flush = 1'b1;
    issue(3'd4, 32'h999, 32'd0);
    chk("fl_mthi_stall", 32'(stall), 32'd0);
    tick();
    chk("fl_mthi_hi", hi, 32'h1234);
    issue(3'd3, 32'd100, 32'd7);
    chk("fl_div_stall", 32'(stall), 32'd0);
    tick();
    chk("fl_div_done", 32'(done), 32'd0);
    flush = 1'b0;

    // No-op codes
    issue(3'd6, 32'h777, 32'd1);
    chk("nop6_stall", 32'(stall), 32'd0);
    tick();
    issue(3'd7, 32'h777, 32'd1);
    chk("nop7_stall", 32'(stall), 32'd0);
    tick();
    chk("nop_done", 32'(done), 32'd0);
    chk("nop_hi", hi, 32'h1234);
    chk("nop_lo", lo, 32'h5678);
    idle_in();

    // DIVU flushed at counter 10, then immediate DIVU 9/4
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 11; i++) tick();
    flush = 1'b1;
    #1;
    chk("fdiv_stall_c11", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    chk("fdiv_done", 32'(done), 32'd0);
    chk("fdiv_hi", hi, 32'h1234);
    chk("fdiv_lo", lo, 32'h5678);
    issue(3'd3, 32'd9, 32'd4);
    run_stall(ns);
    chk("div94_stalls", ns, 32'd33);
    chk("div94_done", 32'(done), 32'd1);
    chk("div94_lo", lo, 32'd2);
    chk("div94_hi", hi, 32'd1);
    idle_in();
    tick();

    // Flush during DONE keeps the committed result
    issue(3'd0, 32'd2, 32'd3);
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("fdone_done", 32'(done), 32'd1);
    chk("fdone_lo", lo, 32'd6);
    tick();
    flush = 1'b0;
    idle_in();
    #1;
    chk("fdone_lo_after", lo, 32'd6);
    chk("fdone_hi_after", hi, 32'd0);

    // Reset mid-DIV
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    chk("rdiv_stall", 32'(stall), 32'd0);
    chk("rdiv_done", 32'(done), 32'd0);
    tick();
    idle_in();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || stall === 1'b1) nd++;
    end
    chk("rdiv_quiet", nd, 32'd0);

    // MULT followed back-to-back by MTLO
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_stall(ns);
    chk("b2b_stalls", ns, 32'd2);
    chk("b2b_done", 32'(done), 32'd1);
    tick();
    issue(3'd5, 32'hAA, 32'd0);
    chk("b2b_mtlo_stall", 32'(stall), 32'd0);
    chk("b2b_done_off", 32'(done), 32'd0);
    tick();
    idle_in();
    chk("b2b_lo", lo, 32'hAA);
    chk("b2b_hi", hi, 32'hFFFF_FFFF);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
